// File: rtl/fpu_writeback.sv
// fpu_writeback
// Write-back merge unit between the FPU result stream and the single
// register-file write port.
//  - Integer-pipe writes always win the port.
//  - FPU results are queued in a DEPTH-entry FIFO and leave in arrival order.
//  - A per-float-register scoreboard (busy) tracks results still in flight.
//    It drives stall (no room or WAW) and hazard (RAW) back to decode.
//
// Parameters: DEPTH  FPU result FIFO entries (2..8)
// Config macro: FPU_WB_BYPASS_EN
//   When defined, an FPU result goes straight to the port if the FIFO is
//   empty and no integer write is present (1-cycle latency).
//   When undefined, every FPU result passes through the FIFO (2 cycles minimum).
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   issue_valid/issue_addr           decode issues an FPU op
//   src_a/src_b, src_a_use/src_b_use float sources of the op in decode
//   fpu_enable/addr/data/float       FPU result stream
//   int_enable/addr/data/float       integer-pipe write
//   wr_enable/addr/data/float        registered register-file write port
//   stall, hazard                    combinational decode controls
//   busy                             per-float-register pending mask
module fpu_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    input  logic        src_a_use,
    input  logic        src_b_use,
    input  logic        fpu_enable,
    input  logic [4:0]  fpu_addr,
    input  logic [31:0] fpu_data,
    input  logic        fpu_float,
    input  logic        int_enable,
    input  logic [4:0]  int_addr,
    input  logic [31:0] int_data,
    input  logic        int_float,
    output logic        wr_enable,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_float,
    output logic        stall,
    output logic        hazard,
    output logic [31:0] busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
`ifdef FPU_WB_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {SRC_NONE, SRC_INT, SRC_FIFO, SRC_BYP} src_e;

    // FIFO pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [4:0]       q_addr_r  [DEPTH];
    logic [31:0]      q_data_r  [DEPTH];
    logic             q_float_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [3:0]       pending_r, pending_nxt_s;
    logic [31:0]      busy_r, busy_nxt_s;
    logic             wr_enable_r, wr_float_r, wr_fpu_r;
    logic [4:0]       wr_addr_r;
    logic [31:0]      wr_data_r;

    src_e             src_s;
    logic             pop_s, push_s, bypass_s, accept_s, stall_s;
    logic [4:0]       occ_s;
    logic             wr_enable_s, wr_float_s, wr_fpu_s;
    logic [4:0]       wr_addr_s;
    logic [31:0]      wr_data_s;
    logic [31:0]      clr_mask_s, set_mask_s;

    // Decode controls: FIFO slots must cover every result still in flight
    always_comb begin
        occ_s    = 5'(count_r) + 5'(pending_r);
        stall_s  = (occ_s >= 5'(DEPTH)) || busy_r[issue_addr];
        accept_s = issue_valid && !stall_s;
    end

    assign stall  = stall_s;
    assign hazard = (src_a_use && busy_r[src_a]) || (src_b_use && busy_r[src_b]);
    assign busy   = busy_r;

    // Port arbitration: integer, then FIFO head, then FPU bypass
    always_comb begin
        src_s    = SRC_NONE;
        pop_s    = 1'b0;
        bypass_s = 1'b0;
        if (int_enable) begin
            src_s = SRC_INT;
        end else if (count_r != ZERO_C) begin
            src_s = SRC_FIFO;
            pop_s = 1'b1;
        end else if (BYPASS_EN && fpu_enable) begin
            src_s    = SRC_BYP;
            bypass_s = 1'b1;
        end else begin
            src_s = SRC_NONE;
        end
        // a full FIFO without a pop can only be reached by a protocol error
        push_s = fpu_enable && !bypass_s && ((count_r != DEPTH_C) || pop_s);
    end

    // Next value of the registered write port
    always_comb begin
        wr_enable_s = 1'b0;
        wr_fpu_s    = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        wr_float_s  = wr_float_r;
        case (src_s)
            SRC_INT: begin
                wr_enable_s = 1'b1;
                wr_addr_s   = int_addr;
                wr_data_s   = int_data;
                wr_float_s  = int_float;
            end
            SRC_FIFO: begin
                wr_enable_s = 1'b1;
                wr_fpu_s    = 1'b1;
                wr_addr_s   = q_addr_r[rd_ptr_r];
                wr_data_s   = q_data_r[rd_ptr_r];
                wr_float_s  = q_float_r[rd_ptr_r];
            end
            SRC_BYP: begin
                wr_enable_s = 1'b1;
                wr_fpu_s    = 1'b1;
                wr_addr_s   = fpu_addr;
                wr_data_s   = fpu_data;
                wr_float_s  = fpu_float;
            end
            default: begin
                wr_enable_s = 1'b0;
            end
        endcase
    end

    // FIFO occupancy, in-flight count and scoreboard next state
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
        pending_nxt_s = pending_r;
        if (accept_s) begin
            pending_nxt_s = pending_nxt_s + 4'd1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        // an unexpected result leaves pending at zero
        if (fpu_enable && (pending_r != 4'd0)) begin
            pending_nxt_s = pending_nxt_s - 4'd1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        // busy clears the cycle after the FPU write shows on the port
        clr_mask_s = (wr_enable_r && wr_fpu_r) ? (32'd1 << wr_addr_r) : 32'd0;
        set_mask_s = accept_s ? (32'd1 << issue_addr) : 32'd0;
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= ZERO_C;
            pending_r   <= 4'd0;
            busy_r      <= 32'd0;
            wr_enable_r <= 1'b0;
            wr_fpu_r    <= 1'b0;
            wr_addr_r   <= 5'd0;
            wr_data_r   <= 32'd0;
            wr_float_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i]  <= 5'd0;
                q_data_r[i]  <= 32'd0;
                q_float_r[i] <= 1'b0;
            end
        end else begin
            count_r     <= count_nxt_s;
            pending_r   <= pending_nxt_s;
            busy_r      <= busy_nxt_s;
            wr_enable_r <= wr_enable_s;
            wr_fpu_r    <= wr_fpu_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            wr_float_r  <= wr_float_s;
            if (push_s) begin
                q_addr_r[wr_ptr_r]  <= fpu_addr;
                q_data_r[wr_ptr_r]  <= fpu_data;
                q_float_r[wr_ptr_r] <= fpu_float;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign wr_enable = wr_enable_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign wr_float  = wr_float_r;

endmodule

// File: tb/tb_fpu_writeback.sv
// Testbench for fpu_writeback: directed scenarios with literal expectations,
// plus a queue-based reference model checked on every falling edge.
module tb_fpu_writeback;
    localparam int DEPTH = 4;
`ifdef FPU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_addr, src_a, src_b;
    logic        src_a_use, src_b_use;
    logic        fpu_enable, fpu_float, int_enable, int_float;
    logic [4:0]  fpu_addr, int_addr;
    logic [31:0] fpu_data, int_data;
    logic        wr_enable, wr_float, stall, hazard;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, busy;

    int tests = 0;
    int fails = 0;

    fpu_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .src_a(src_a), .src_b(src_b), .src_a_use(src_a_use), .src_b_use(src_b_use),
        .fpu_enable(fpu_enable), .fpu_addr(fpu_addr), .fpu_data(fpu_data), .fpu_float(fpu_float),
        .int_enable(int_enable), .int_addr(int_addr), .int_data(int_data), .int_float(int_float),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_float(wr_float),
        .stall(stall), .hazard(hazard), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        f;
    } ent_t;

    ent_t        mq[$];
    int          m_pending = 0;
    logic [31:0] m_busy = 32'd0;
    bit          m_en = 1'b0;
    bit          m_fpu = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic        m_float = 1'b0;
    bit          model_ok = 1'b0;

    // Falling edge: compare the DUT against the model, then advance the model
    // with the inputs the DUT will sample on the next rising edge.
    initial begin
        bit          exp_stall, exp_hazard, acc, byp;
        logic [31:0] nb;
        ent_t        e;
        forever begin
            @(negedge clk);
            exp_stall  = ((mq.size() + m_pending) >= DEPTH) || m_busy[issue_addr];
            exp_hazard = (src_a_use && m_busy[src_a]) || (src_b_use && m_busy[src_b]);
            if (model_ok) begin
                check("model_wr_enable", {31'd0, wr_enable}, {31'd0, m_en});
                if (m_en) begin
                    check("model_wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
                    check("model_wr_data", wr_data, m_data);
                    check("model_wr_float", {31'd0, wr_float}, {31'd0, m_float});
                end
                check("model_busy", busy, m_busy);
                check("model_stall", {31'd0, stall}, {31'd0, exp_stall});
                check("model_hazard", {31'd0, hazard}, {31'd0, exp_hazard});
            end
            if (!rst_n) begin
                mq.delete();
                m_pending = 0;
                m_busy    = 32'd0;
                m_en      = 1'b0;
                m_fpu     = 1'b0;
                model_ok  = 1'b1;
            end else begin
                acc = issue_valid && !exp_stall;
                nb  = m_busy;
                if (m_en && m_fpu) nb[m_addr] = 1'b0;
                if (acc) nb[issue_addr] = 1'b1;
                byp = 1'b0;
                if (int_enable) begin
                    m_en = 1'b1; m_fpu = 1'b0;
                    m_addr = int_addr; m_data = int_data; m_float = int_float;
                end else if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_en = 1'b1; m_fpu = 1'b1;
                    m_addr = e.a; m_data = e.d; m_float = e.f;
                end else if (BYP && fpu_enable) begin
                    m_en = 1'b1; m_fpu = 1'b1; byp = 1'b1;
                    m_addr = fpu_addr; m_data = fpu_data; m_float = fpu_float;
                end else begin
                    m_en = 1'b0; m_fpu = 1'b0;
                end
                if (fpu_enable && !byp) begin
                    e.a = fpu_addr; e.d = fpu_data; e.f = fpu_float;
                    mq.push_back(e);
                end
                if (acc) m_pending++;
                if (fpu_enable && m_pending > 0) m_pending--;
                m_busy = nb;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_addr = 5'd0;
        src_a = 5'd0; src_b = 5'd0; src_a_use = 1'b0; src_b_use = 1'b0;
        fpu_enable = 1'b0; fpu_addr = 5'd0; fpu_data = 32'd0; fpu_float = 1'b0;
        int_enable = 1'b0; int_addr = 5'd0; int_data = 32'd0; int_float = 1'b0;

        // reset state
        step(); step();
        check("rst_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_wr_float", {31'd0, wr_float}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        rst_n = 1'b1;
        step();

        // single op to f5, result three cycles after issue
        issue_valid = 1'b1; issue_addr = 5'd5; step();
        issue_valid = 1'b0;
        check("single_busy_set", {31'd0, busy[5]}, 32'd1);
        step(); step();
        fpu_enable = 1'b1; fpu_addr = 5'd5; fpu_data = 32'h3F800000; fpu_float = 1'b1;
        step();
        fpu_enable = 1'b0;
        if (!BYP) step();
        check("single_wr_enable", {31'd0, wr_enable}, 32'd1);
        check("single_wr_addr", {27'd0, wr_addr}, 32'd5);
        check("single_wr_data", wr_data, 32'h3F800000);
        check("single_wr_float", {31'd0, wr_float}, 32'd1);
        check("single_busy_held", {31'd0, busy[5]}, 32'd1);
        step();
        check("single_busy_clear", {31'd0, busy[5]}, 32'd0);
        check("single_idle", {31'd0, wr_enable}, 32'd0);

        // contention: three integer writes while f1, f2 return
        issue_valid = 1'b1; issue_addr = 5'd1; step();
        issue_addr = 5'd2; step();
        issue_valid = 1'b0;
        int_enable = 1'b1; int_addr = 5'd10; int_data = 32'hA0; int_float = 1'b0;
        fpu_enable = 1'b1; fpu_addr = 5'd1; fpu_data = 32'h11; fpu_float = 1'b1;
        step();
        check("cont_int0_addr", {27'd0, wr_addr}, 32'd10);
        check("cont_int0_float", {31'd0, wr_float}, 32'd0);
        int_addr = 5'd11; int_data = 32'hA1; fpu_addr = 5'd2; fpu_data = 32'h22;
        step();
        check("cont_int1_addr", {27'd0, wr_addr}, 32'd11);
        int_addr = 5'd12; int_data = 32'hA2; fpu_enable = 1'b0;
        step();
        check("cont_int2_addr", {27'd0, wr_addr}, 32'd12);
        int_enable = 1'b0;
        step();
        check("cont_f1_addr", {27'd0, wr_addr}, 32'd1);
        check("cont_f1_data", wr_data, 32'h11);
        step();
        check("cont_f2_addr", {27'd0, wr_addr}, 32'd2);
        check("cont_f2_data", wr_data, 32'h22);
        step();
        check("cont_busy_clear", {30'd0, busy[2:1]}, 32'd0);

        // back-pressure: four issues with the port held by integer writes
        int_enable = 1'b1; int_addr = 5'd20; int_data = 32'hB0; int_float = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1'b1; issue_addr = 5'(i); step();
        end
        issue_addr = 5'd6; #1;
        check("bp_stall_full", {31'd0, stall}, 32'd1);
        step();
        issue_valid = 1'b0;
        check("bp_fifth_ignored", {31'd0, busy[6]}, 32'd0);
        check("bp_busy_1to4", {28'd0, busy[4:1]}, 32'hF);
        for (int i = 1; i <= 4; i++) begin
            fpu_enable = 1'b1; fpu_addr = 5'(i); fpu_data = 32'hC0 + 32'(i); fpu_float = 1'b1;
            step();
        end
        fpu_enable = 1'b0; #1;
        check("bp_stall_queued", {31'd0, stall}, 32'd1);
        int_enable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("bp_drain_addr", {27'd0, wr_addr}, 32'(i));
            check("bp_drain_data", wr_data, 32'hC0 + 32'(i));
            check("bp_drain_stall", {31'd0, stall}, 32'd0);
        end
        step();

        // WAW / RAW on f7
        issue_valid = 1'b1; issue_addr = 5'd7; step();
        src_a = 5'd7; src_a_use = 1'b1; #1;
        check("waw_stall", {31'd0, stall}, 32'd1);
        check("raw_hazard_a", {31'd0, hazard}, 32'd1);
        step();
        issue_valid = 1'b0;
        check("waw_busy7", {31'd0, busy[7]}, 32'd1);
        src_a_use = 1'b0; src_b = 5'd7; src_b_use = 1'b0; #1;
        check("raw_unused", {31'd0, hazard}, 32'd0);
        src_b_use = 1'b1; #1;
        check("raw_hazard_b", {31'd0, hazard}, 32'd1);
        src_b_use = 1'b0; src_a_use = 1'b1;
        fpu_enable = 1'b1; fpu_addr = 5'd7; fpu_data = 32'h40000000; fpu_float = 1'b1;
        step();
        fpu_enable = 1'b0;
        if (!BYP) step();
        check("raw_wr_addr", {27'd0, wr_addr}, 32'd7);
        check("raw_hazard_held", {31'd0, hazard}, 32'd1);
        step();
        check("raw_hazard_clear", {31'd0, hazard}, 32'd0);
        check("waw_stall_clear", {31'd0, stall}, 32'd0);
        src_a_use = 1'b0;

        // simultaneous push and pop with one queued entry
        issue_valid = 1'b1; issue_addr = 5'd8; step();
        issue_addr = 5'd9; step();
        issue_valid = 1'b0;
        int_enable = 1'b1; int_addr = 5'd21; int_data = 32'hD0; int_float = 1'b0;
        fpu_enable = 1'b1; fpu_addr = 5'd8; fpu_data = 32'h88; fpu_float = 1'b1;
        step();
        check("pp_int_addr", {27'd0, wr_addr}, 32'd21);
        int_enable = 1'b0; fpu_addr = 5'd9; fpu_data = 32'h99;
        step();
        check("pp_head_addr", {27'd0, wr_addr}, 32'd8);
        check("pp_head_data", wr_data, 32'h88);
        fpu_enable = 1'b0;
        step();
        check("pp_next_addr", {27'd0, wr_addr}, 32'd9);
        check("pp_next_data", wr_data, 32'h99);
        step();
        check("pp_empty", {31'd0, wr_enable}, 32'd0);

        // reset with two queued results and busy[3] set
        issue_valid = 1'b1; issue_addr = 5'd3; step();
        issue_addr = 5'd13; step();
        issue_valid = 1'b0; issue_addr = 5'd3;
        int_enable = 1'b1; int_addr = 5'd22; int_data = 32'hE0; int_float = 1'b0;
        fpu_enable = 1'b1; fpu_addr = 5'd3; fpu_data = 32'h33; fpu_float = 1'b1;
        step();
        fpu_addr = 5'd13; fpu_data = 32'h1313;
        step();
        check("mrst_busy3_before", {31'd0, busy[3]}, 32'd1);
        int_enable = 1'b0; fpu_addr = 5'd14; fpu_data = 32'hEE; rst_n = 1'b0;
        step();
        rst_n = 1'b1; fpu_enable = 1'b0;
        check("mrst_wr_enable", {31'd0, wr_enable}, 32'd0);
        check("mrst_busy", busy, 32'd0);
        check("mrst_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_no_write", {31'd0, wr_enable}, 32'd0);
        end

        // unexpected result: still written, in-flight count stays at zero
        fpu_enable = 1'b1; fpu_addr = 5'd15; fpu_data = 32'h55; fpu_float = 1'b1;
        step();
        fpu_enable = 1'b0;
        if (!BYP) step();
        check("proto_wr_addr", {27'd0, wr_addr}, 32'd15);
        check("proto_wr_data", wr_data, 32'h55);
        check("proto_stall", {31'd0, stall}, 32'd0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
